// File: rtl/matmul_stream_io_pkg.sv
// matmul_stream_io_pkg: shared constants, FSM state encoding and flat-bus indexing
package matmul_stream_io_pkg;
    localparam int N  = 4;
    localparam int EW = 3;
    localparam int RW = 8;
    localparam int NE = N * N;
    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;
    function automatic int off(input int r, input int c, input int w);
        return (r * N + c) * w;
    endfunction
endpackage

// File: rtl/mm_result_drain.sv
// mm_result_drain: result bank capture and row-major valid/ready drain with last marker
//   capture  : registers res_flat into the bank and starts the drain
//   out_*    : result stream, out_data muxed from bank registers only
//   done     : pulses on the accepted last beat
module mm_result_drain
    import matmul_stream_io_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             capture,
    input  logic [NE*RW-1:0] res_flat,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [RW-1:0]    out_data,
    output logic             out_last,
    output logic             done
);
    logic [NE*RW-1:0] bank;
    logic [3:0]       idx;
    logic             fire;
    assign fire     = out_valid & out_ready & ~clear;
    assign out_data = bank[off(int'(idx[3:2]), int'(idx[1:0]), RW) +: RW];
    assign out_last = out_valid & (idx == 4'(NE - 1));
    assign done     = fire & out_last;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bank      <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            idx       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (capture) begin
                bank      <= res_flat;
                out_valid <= 1'b1;
            end
            if (fire) begin
                idx <= idx + 4'd1;
                if (out_last) out_valid <= 1'b0;
            end
        end
endmodule

// File: rtl/matmul_stream_io.sv
// matmul_stream_io: serial operand loader and result drainer around a combinational 4x4 multiplier
//   in_*     : operand stream, A row-major then B row-major
//   mat_a/b  : flat operand buses held for the multiplier
//   res_flat : multiplier results, captured SETTLE cycles after the last B beat
//   out_*    : result stream; busy covers COMPUTE and DRAIN
module matmul_stream_io
    import matmul_stream_io_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EW-1:0]    in_data,
    output logic [NE*EW-1:0] mat_a,
    output logic [NE*EW-1:0] mat_b,
    input  logic [NE*RW-1:0] res_flat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_data,
    output logic             out_last,
    output logic             busy
);
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("matmul_stream_io: SETTLE must be in 1..15");
    end
    state_t     state;
    logic [3:0] idx;
    logic [3:0] cnt;
    logic       take;
    logic       cap;
    logic       done;
    assign in_ready = ~state[1];
    assign busy     = state[1];
    assign take     = in_valid & in_ready & ~clear;
    assign cap      = (state == COMPUTE) & (cnt == 4'(SETTLE - 1)) & ~clear;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= LOAD_A;
            idx   <= '0;
            cnt   <= '0;
            mat_a <= '0;
            mat_b <= '0;
        end else if (clear) begin
            state <= LOAD_A;
            idx   <= '0;
        end else if (state == COMPUTE) begin
            cnt <= cnt + 4'd1;
            if (cap) state <= DRAIN;
        end else if (state == DRAIN) begin
            if (done) state <= LOAD_A;
        end else if (take) begin
            if (state == LOAD_A) mat_a[off(int'(idx[3:2]), int'(idx[1:0]), EW) +: EW] <= in_data;
            else mat_b[off(int'(idx[3:2]), int'(idx[1:0]), EW) +: EW] <= in_data;
            idx <= idx + 4'd1;
            if (idx == 4'(NE - 1)) begin
                state <= (state == LOAD_A) ? LOAD_B : COMPUTE;
                cnt   <= '0;
            end
        end
    mm_result_drain u_drain (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .capture   (cap),
        .res_flat  (res_flat),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done)
    );
endmodule
